midi_in_parser: RTL

Turns the raw MIDI byte stream from the UART receiver into the status-qualified byte strobes that `midi_decoder` consumes. It tracks running status, counts bytes within a message, and diverts real-time bytes to a separate output. It also spaces strobes so that every byte produces a clean falling edge on `byteready`. It sits between the UART RX and `midi_decoder`, in the `CLOCK_25` domain.

---
 rtl/midi_in_parser_pkg.sv | 67 ++++++
 rtl/midi_in_parser_if.sv | 36 +++
 rtl/midi_in_parser_skid.sv | 35 +++
 rtl/midi_in_parser.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/midi_in_parser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Packages  : utils, midi_pkg                                                 |
// | Purpose   : Shared helpers and MIDI constants for midi_in_parser.           |
// |             utils::clogb2  - counter width for a given maximum count.       |
// |             midi_pkg       - status nibbles, sysex/real-time markers,       |
// |                              strobe FSM state type, msg_len().              |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package utils;

  // Bits needed to count 0..value-1; never returns less than 1 so a
  // length of 1 still yields a legal vector.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PRG      = 4'hC;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [3:0] SYS      = 4'hF;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } strobe_state_t;

  // Expected number of data bytes following a status byte.
  // 0xFF marks sysex (open-ended).
  function automatic logic [7:0] msg_len(input logic [7:0] status);
    logic [7:0] len;
    len = 8'd0;
    case (status[7:4])
      NOTE_OFF, NOTE_ON, 4'hA, CTRL, PITCH: len = 8'd2;
      PRG, 4'hD:                            len = 8'd1;
      SYS: begin
        case (status[3:0])
          4'h0:       len = 8'hFF;
          4'h1, 4'h3: len = 8'd1;
          4'h2:       len = 8'd2;
          default:    len = 8'd0;
        endcase
      end
      default: len = 8'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_in_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : midi_in_parser_if                                              |
// | Purpose   : Byte-in / strobe-out bundle of the MIDI input parser.          |
// | Ports     : rx_valid, rx_byte               (source -> parser)             |
// |             byteready, cur_status, midi_bytes, databyte, rt_valid,        |
// |             rt_byte, sysex_end, orphan_cnt, overrun  (parser -> sink)     |
// |             master = UART side / bench, slave = parser                    |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface midi_in_parser_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       byteready;
  logic [7:0] cur_status;
  logic [7:0] midi_bytes;
  logic [7:0] databyte;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       sysex_end;
  logic [7:0] orphan_cnt;
  logic       overrun;

  modport master (
    output rx_valid, rx_byte,
    input  byteready, cur_status, midi_bytes, databyte,
           rt_valid, rt_byte, sysex_end, orphan_cnt, overrun
  );

  modport slave (
    input  rx_valid, rx_byte,
    output byteready, cur_status, midi_bytes, databyte,
           rt_valid, rt_byte, sysex_end, orphan_cnt, overrun
  );
endinterface
`default_nettype wire

// File: rtl/midi_in_parser_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : midi_byte_skid                                                  |
// | Purpose   : One-entry byte holding register.                               |
// | Ports     : clk, rst        clock / sync active-high reset                 |
// |             push, push_data load an entry (may coincide with pop)          |
// |             pop             release the held entry                         |
// |             full, data      entry present / held byte                      |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module midi_byte_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic [7:0] data
);

  // Push wins over pop: a simultaneous pop+push refills the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= 8'h00;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/midi_in_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : midi_in_parser                                                  |
// | Purpose   : Turns the UART MIDI byte stream into status-qualified byte     |
// |             strobes: running status, message byte index, real-time        |
// |             diversion, sysex tracking and strobe spacing.                  |
// | Ports     : CLOCK_25  system clock                                         |
// |             iRST      sync active-high reset                               |
// |             bus       midi_in_parser_if.slave (rx in, strobes out)         |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module midi_in_parser
  import midi_pkg::*;
#(
  parameter int STROBE_LEN = 4,
  parameter int GAP_LEN    = 2
) (
  input  logic            CLOCK_25,
  input  logic            iRST,
  midi_in_parser_if.slave bus
);

  localparam int MAX_LEN = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
  localparam int CW      = utils::clogb2(MAX_LEN);
  localparam logic [CW-1:0] HIGH_LAST = CW'(STROBE_LEN - 1);
  // The IDLE cycle that follows LOW is itself a low cycle, so LOW only
  // needs GAP_LEN-1 cycles to give GAP_LEN low cycles between strobes.
  localparam logic [CW-1:0] LOW_LAST  = CW'((GAP_LEN > 1) ? GAP_LEN - 2 : 0);

  strobe_state_t state, state_nxt;
  logic [CW-1:0] scnt, scnt_nxt;

  logic [7:0] run_status;  // status governing the next data byte (00 = none)
  logic [7:0] msg_cnt;     // data bytes seen in the current message
  logic [7:0] out_status, out_mbytes, out_data, orphan_q, rt_byte_q;
  logic       rt_valid_q, sysex_end_q, overrun_q;

  logic       skid_full, skid_push, skid_pop;
  logic [7:0] skid_data;

  logic       idle, rx_rt, rx_nrt, proc_valid;
  logic [7:0] proc_byte;

  logic       p_emit, p_sx_end, p_orphan;
  logic [7:0] p_run, p_cnt, p_status, p_mbytes, len, inc;

  assign idle   = (state == ST_IDLE);
  assign rx_rt  = bus.rx_valid && (bus.rx_byte >= RT_MIN);
  assign rx_nrt = bus.rx_valid && (bus.rx_byte < RT_MIN);

  // In IDLE a held byte goes first; the incoming byte then refills the skid.
  assign proc_valid = idle && (skid_full || rx_nrt);
  assign proc_byte  = skid_full ? skid_data : bus.rx_byte;
  assign skid_pop   = idle && skid_full;
  assign skid_push  = rx_nrt && (idle ? skid_full : !skid_full);

  midi_byte_skid u_skid (
    .clk       (CLOCK_25),
    .rst       (iRST),
    .push      (skid_push),
    .push_data (bus.rx_byte),
    .pop       (skid_pop),
    .full      (skid_full),
    .data      (skid_data)
  );

  // Byte classification for the head-of-pipeline byte.
  always_comb begin
    p_emit   = 1'b0;
    p_sx_end = 1'b0;
    p_orphan = 1'b0;
    p_run    = run_status;
    p_cnt    = msg_cnt;
    p_status = out_status;
    p_mbytes = out_mbytes;
    len      = msg_len(run_status);
    inc      = msg_cnt + 8'd1;
    if (proc_byte[7]) begin
      if (proc_byte == SYSEX_END) begin
        if (run_status == SYSEX_START) begin
          p_sx_end = 1'b1;
          p_run    = 8'h00;
          p_status = 8'h00;
        end
      end else if (proc_byte == 8'hF4 || proc_byte == 8'hF5) begin
        p_run    = 8'h00;
        p_cnt    = 8'h00;
        p_status = 8'h00;
      end else begin
        // F6 has no data bytes: it is emitted but leaves no status in force.
        p_emit   = 1'b1;
        p_run    = (proc_byte == 8'hF6) ? 8'h00 : proc_byte;
        p_cnt    = 8'h00;
        p_status = proc_byte;
        p_mbytes = 8'h00;
      end
    end else if (run_status == 8'h00) begin
      p_orphan = 1'b1;
    end else begin
      if (run_status == SYSEX_START)
        inc = (msg_cnt == 8'hFF) ? 8'hFF : msg_cnt + 8'd1;
      else if (msg_cnt == len)
        inc = 8'd1;  // running status restarts the data index
      p_emit   = 1'b1;
      p_cnt    = inc;
      p_status = run_status;
      p_mbytes = inc;
      // Completed system common message: no running status.
      if (run_status[7:4] == SYS && run_status != SYSEX_START && inc == len)
        p_run = 8'h00;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      run_status  <= 8'h00;
      msg_cnt     <= 8'h00;
      out_status  <= 8'h00;
      out_mbytes  <= 8'h00;
      out_data    <= 8'h00;
      orphan_q    <= 8'h00;
      rt_valid_q  <= 1'b0;
      rt_byte_q   <= 8'h00;
      sysex_end_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rt_valid_q  <= rx_rt;
      if (rx_rt) rt_byte_q <= bus.rx_byte;
      sysex_end_q <= proc_valid && p_sx_end;
      if (rx_nrt && !idle && skid_full) overrun_q <= 1'b1;
      if (proc_valid) begin
        run_status <= p_run;
        msg_cnt    <= p_cnt;
        out_status <= p_status;
        if (p_emit) begin
          out_mbytes <= p_mbytes;
          out_data   <= proc_byte;
        end
        if (p_orphan && orphan_q != 8'hFF) orphan_q <= orphan_q + 8'd1;
      end
    end
  end

  // Strobe FSM: state register.
  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      state <= ST_IDLE;
      scnt  <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
    end
  end

  // Strobe FSM: next state.
  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    case (state)
      ST_IDLE: begin
        if (proc_valid && p_emit) begin
          state_nxt = ST_HIGH;
          scnt_nxt  = '0;
        end
      end
      ST_HIGH: begin
        if (scnt == HIGH_LAST) begin
          state_nxt = (GAP_LEN > 1) ? ST_LOW : ST_IDLE;
          scnt_nxt  = '0;
        end else begin
          scnt_nxt = scnt + CW'(1);
        end
      end
      ST_LOW: begin
        if (scnt == LOW_LAST) begin
          state_nxt = ST_IDLE;
          scnt_nxt  = '0;
        end else begin
          scnt_nxt = scnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        scnt_nxt  = '0;
      end
    endcase
  end

  assign bus.byteready  = (state == ST_HIGH);
  assign bus.cur_status = out_status;
  assign bus.midi_bytes = out_mbytes;
  assign bus.databyte   = out_data;
  assign bus.rt_valid   = rt_valid_q;
  assign bus.rt_byte    = rt_byte_q;
  assign bus.sysex_end  = sysex_end_q;
  assign bus.orphan_cnt = orphan_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire
